ntt_poly_buffer: RTL and testbench

- Polynomial I/O buffer that sits in front of `ntt_memory_wrapper`.
- Accepts N coefficients from a host valid/ready stream and stores them.
- Starts the NTT core in forward or inverse mode, serves its read requests with 1-cycle latency and captures its write-back outputs.
- Streams the transformed polynomial back to the host in natural index order.

---
 rtl/ntt_poly_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_ntt_poly_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_poly_buffer.sv
// ntt_poly_buffer
// Polynomial I/O buffer in front of the NTT memory wrapper. It collects N
// coefficients from a host stream into the source array, holds the core's
// start line while serving its reads (one-cycle latency) and capturing its
// write-backs into the destination array, then streams the destination
// array back to the host in natural index order.
//
// Build option: define NTT_POLY_BUFFER_REDUCE_EN to fold each loaded
// coefficient into [0, q) with one conditional subtraction before it is
// stored. Without it, coefficients are stored exactly as received.
module ntt_poly_buffer #(
    parameter int LOGQ = 64,
    parameter int LOGN = 12,
    parameter int AW   = (LOGN < 9) ? 10 : LOGN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOGQ-1:0]   q_in,
    input  logic              in_intt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOGQ-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOGQ-1:0]   out_data,
    output logic              out_last,
    output logic              busy,
    output logic              ntt_start,
    output logic              ntt_intt,
    output logic [LOGQ-1:0]   ntt_q,
    input  logic [AW-1:0]     ntt_read_address,
    output logic [LOGQ-1:0]   ntt_data_in,
    input  logic [AW-1:0]     ntt_write_address,
    input  logic              ntt_wea,
    input  logic [LOGQ-1:0]   ntt_data_out,
    input  logic              ntt_finish
);

    localparam int N = 1 << LOGN;
    localparam logic [LOGN:0] LAST = (LOGN+1)'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state_reg;

    // Phase counters carry one spare bit so they can be compared against N
    // without aliasing.
    logic [LOGN:0]     load_cnt_reg;
    logic [LOGN:0]     drain_cnt_reg;

    logic              in_ready_reg;
    logic              busy_reg;
    logic              start_reg;
    logic              intt_reg;
    logic [LOGQ-1:0]   q_reg;
    logic              out_valid_reg;
    logic              out_last_reg;

    // Coefficient storage; never reset so it maps onto block RAM.
    logic [LOGQ-1:0]   src_mem [N];
    logic [LOGQ-1:0]   dst_mem [N];

    logic [LOGQ-1:0]   src_rd_reg;
    logic              src_rd_ok_reg;
    logic [LOGQ-1:0]   dst_rd_reg;

    logic              load_fire;
    logic              load_last;
    logic              out_fire;
    logic              drain_last;
    logic              drain_prime;
    logic              rd_load;
    logic [LOGN-1:0]   rd_idx;
    logic              rd_addr_ok;
    logic              wr_addr_ok;
    logic              src_we;
    logic              dst_we;
    logic [LOGQ-1:0]   store_data;

    // in_ready_reg is only ever high in LOAD, so it doubles as the state gate.
    assign load_fire  = in_valid && in_ready_reg;
    assign load_last  = (load_cnt_reg == LAST);
    assign out_fire   = out_valid_reg && out_ready;
    assign drain_last = (drain_cnt_reg == LAST);

    // The first DRAIN cycle has nothing presented yet; it primes the output
    // register with dst[0]. After that each handshake refetches the next index,
    // so the output register itself acts as the prefetch stage.
    assign drain_prime = (state_reg == DRAIN) && !out_valid_reg;
    assign rd_load     = drain_prime || (out_fire && !drain_last);
    assign rd_idx      = drain_prime ? drain_cnt_reg[LOGN-1:0]
                                     : drain_cnt_reg[LOGN-1:0] + LOGN'(1);

    // Core addresses at or beyond N fall outside the polynomial.
    assign rd_addr_ok = ((ntt_read_address  >> LOGN) == '0);
    assign wr_addr_ok = ((ntt_write_address >> LOGN) == '0);

    assign src_we = load_fire;
    assign dst_we = (state_reg == RUN) && ntt_wea && wr_addr_ok;

`ifdef NTT_POLY_BUFFER_REDUCE_EN
    logic [LOGQ-1:0]   q_eff;

    // Beat 0 has not latched the modulus yet, so it reduces against q_in.
    always_comb begin
        q_eff      = (load_cnt_reg == '0) ? q_in : q_reg;
        store_data = (in_data >= q_eff) ? (in_data - q_eff) : in_data;
    end
`else
    assign store_data = in_data;
`endif

    // Source array: host writes in LOAD, core reads with one cycle of latency.
    always_ff @(posedge clk) begin
        if (src_we) begin
            src_mem[load_cnt_reg[LOGN-1:0]] <= store_data;
        end
        src_rd_reg <= src_mem[ntt_read_address[LOGN-1:0]];
    end

    // Destination array: core writes in RUN, drain logic reads in DRAIN.
    always_ff @(posedge clk) begin
        if (dst_we) begin
            dst_mem[ntt_write_address[LOGN-1:0]] <= ntt_data_out;
        end
        if (rd_load) begin
            dst_rd_reg <= dst_mem[rd_idx];
        end
    end

    // Qualifies the core read data: zero outside RUN or for out-of-range reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_rd_ok_reg <= 1'b0;
        end else begin
            src_rd_ok_reg <= (state_reg == RUN) && rd_addr_ok;
        end
    end

    // Main sequencer: load, run the core, drain, then back to load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            load_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            start_reg     <= 1'b0;
            intt_reg      <= 1'b0;
            q_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= LOAD;
                    load_cnt_reg  <= '0;
                    drain_cnt_reg <= '0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b1;
                end

                LOAD: begin
                    if (load_fire) begin
                        if (load_cnt_reg == '0) begin
                            q_reg    <= q_in;
                            intt_reg <= in_intt;
                        end
                        if (load_last) begin
                            state_reg    <= RUN;
                            load_cnt_reg <= '0;
                            in_ready_reg <= 1'b0;
                            start_reg    <= 1'b1;
                        end else begin
                            load_cnt_reg <= load_cnt_reg + 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (ntt_finish) begin
                        state_reg     <= DRAIN;
                        start_reg     <= 1'b0;
                        drain_cnt_reg <= '0;
                    end
                end

                DRAIN: begin
                    if (drain_prime) begin
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= drain_last;
                    end else if (out_fire) begin
                        if (drain_last) begin
                            state_reg     <= LOAD;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            load_cnt_reg  <= '0;
                            drain_cnt_reg <= '0;
                        end else begin
                            drain_cnt_reg <= drain_cnt_reg + 1'b1;
                            out_last_reg  <= ((drain_cnt_reg + 1'b1) == LAST);
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign busy        = busy_reg;
    assign ntt_start   = start_reg;
    assign ntt_intt    = intt_reg;
    assign ntt_q       = q_reg;
    assign ntt_data_in = src_rd_ok_reg ? src_rd_reg : '0;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_valid_reg ? dst_rd_reg : '0;
    assign out_last    = out_last_reg;

endmodule

// File: tb/tb_ntt_poly_buffer.sv
// Testbench for ntt_poly_buffer (LOGN=3, LOGQ=32) with a behavioural core
// that reads every source word and writes (word ^ mask) to (address ^ pxor).
module tb_ntt_poly_buffer;

    localparam int LOGQ = 32;
    localparam int LOGN = 3;
    localparam int AW   = 10;
    localparam int N    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [LOGQ-1:0]   q_in;
    logic              in_intt;
    logic              in_valid;
    logic              in_ready;
    logic [LOGQ-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LOGQ-1:0]   out_data;
    logic              out_last;
    logic              busy;
    logic              ntt_start;
    logic              ntt_intt;
    logic [LOGQ-1:0]   ntt_q;
    logic [AW-1:0]     ntt_read_address;
    logic [LOGQ-1:0]   ntt_data_in;
    logic [AW-1:0]     ntt_write_address;
    logic              ntt_wea;
    logic [LOGQ-1:0]   ntt_data_out;
    logic              ntt_finish;

    ntt_poly_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .in_intt(in_intt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .ntt_start(ntt_start),
        .ntt_intt(ntt_intt), .ntt_q(ntt_q),
        .ntt_read_address(ntt_read_address), .ntt_data_in(ntt_data_in),
        .ntt_write_address(ntt_write_address), .ntt_wea(ntt_wea),
        .ntt_data_out(ntt_data_out), .ntt_finish(ntt_finish)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Per-transaction setup shared with the core model.
    int          core_pxor = 0;
    logic [31:0] core_mask = '0;
    logic [31:0] cur_q     = '0;
    logic        cur_intt  = 1'b0;

    typedef struct {
        logic [N-1:0][31:0] din;
        logic [N-1:0][31:0] exp;
        logic [31:0]        q;
        logic               intt;
        int                 pxor;
        logic [31:0]        mask;
        int                 rk;     // 0 always ready, 1 pattern 1,0,0,1, 2 random
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Value the buffer is expected to store for a loaded coefficient.
    function automatic logic [31:0] model_store(input logic [31:0] x, input logic [31:0] q);
`ifdef NTT_POLY_BUFFER_REDUCE_EN
        return (x >= q) ? x - q : x;
`else
        return x;
`endif
    endfunction

    // Behavioural NTT core: reads 0..N-1, writes each word back one cycle later.
    task automatic run_core();
        logic [31:0] last_data;
        check("core_q", ntt_q, cur_q);
        check("core_intt", ntt_intt, cur_intt);
        for (int a = 0; a < N; a++) begin
            ntt_read_address  = AW'(a);
            ntt_wea           = (a > 0);
            ntt_write_address = AW'(((a + N - 1) % N) ^ core_pxor);
            ntt_data_out      = ntt_data_in ^ core_mask;
            @(posedge clk); #1;
        end
        last_data         = ntt_data_in;
        // Out-of-range read and a stray write to address 9 (aliases 1 if truncated).
        ntt_read_address  = AW'(10);
        ntt_wea           = 1'b1;
        ntt_write_address = AW'(9);
        ntt_data_out      = 32'hDEAD_0009;
        @(posedge clk); #1;
        check("rd_oob_zero", ntt_data_in, 0);
        // Final write-back lands in the same cycle as finish.
        ntt_read_address  = '0;
        ntt_wea           = 1'b1;
        ntt_write_address = AW'((N - 1) ^ core_pxor);
        ntt_data_out      = last_data ^ core_mask;
        ntt_finish        = 1'b1;
        @(posedge clk); #1;
        ntt_wea    = 1'b0;
        ntt_finish = 1'b0;
        check("start_drop", ntt_start, 0);
        check("valid_not_yet", out_valid, 0);
        @(posedge clk); #1;
        check("valid_rise", out_valid, 1);
    endtask

    always begin
        @(posedge clk); #1;
        if (ntt_start === 1'b1) run_core();
    end

    task automatic load(input logic [N-1:0][31:0] din, input logic [31:0] q,
                        input logic intt, input int gap_pct);
        int   beat = 0;
        int   cyc  = 0;
        logic rdy;
        while (beat < N && cyc < 200) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = din[beat];
            q_in     = (beat == 0) ? q : $urandom;
            in_intt  = (beat == 0) ? intt : 1'($urandom);
            rdy      = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (in_valid && rdy) beat++;
        end
        in_valid = 1'b0;
        if (beat < N) begin
            check("load_timeout", beat, N);
        end else begin
            check("start_rise", ntt_start, 1);
            check("ready_fall", in_ready, 0);
        end
    endtask

    task automatic drain(input logic [N-1:0][31:0] exp, input int rk, output int got);
        int          cyc    = 0;
        logic        pv;
        logic        plast;
        logic [31:0] pd     = '0;
        logic        pstall = 1'b0;
        logic [3:0]  pat    = 4'b1001;
        got = 0;
        while (got < N && cyc < 400) begin
            if (pstall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
            end
            case (rk)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom);
            endcase
            pv    = out_valid;
            pd    = out_data;
            plast = out_last;
            @(posedge clk); #1;
            cyc++;
            if (pv && out_ready) begin
                check($sformatf("data[%0d]", got), pd, exp[got]);
                check($sformatf("last[%0d]", got), plast, (got == N - 1));
                got++;
                pstall = 1'b0;
            end else begin
                pstall = pv;
            end
        end
        out_ready = 1'b0;
        check("handshakes", got, N);
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
    endtask

    task automatic run_txn(input string nm, input vec_t v, input int gap_pct);
        int got;
        cur_q     = v.q;
        cur_intt  = v.intt;
        core_pxor = v.pxor;
        core_mask = v.mask;
        load(v.din, v.q, v.intt, gap_pct);
        drain(v.exp, v.rk, got);
        $display("[TB] txn %s: q=0x%0h intt=%0d pxor=%0d mask=0x%0h drained=%0d",
                 nm, v.q, v.intt, v.pxor, v.mask, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;

        // Vector table.
        vecs[0].din  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        vecs[0].exp  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        vecs[0].q    = 32'hFFFF_FFF1; vecs[0].intt = 1'b0; vecs[0].pxor = 0;
        vecs[0].mask = 32'h0;         vecs[0].rk   = 0;

        vecs[1].din  = {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
        vecs[1].exp  = {32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
        vecs[1].q    = 32'hFFFF_FFF1; vecs[1].intt = 1'b1; vecs[1].pxor = 7;
        vecs[1].mask = 32'h0;         vecs[1].rk   = 1;

        vecs[2].din  = {32'hABCD, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        vecs[2].exp  = {32'hABCD, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        vecs[2].q    = 32'hFFFF_FFF1; vecs[2].intt = 1'b0; vecs[2].pxor = 0;
        vecs[2].mask = 32'h0;         vecs[2].rk   = 0;

        vecs[3].din  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        vecs[3].exp  = {32'hF0F4, 32'hF0F5, 32'hF0F6, 32'hF0F7,
                        32'hF0F0, 32'hF0F1, 32'hF0F2, 32'hF0F3};
        vecs[3].q    = 32'hFFFF_FFF1; vecs[3].intt = 1'b1; vecs[3].pxor = 3;
        vecs[3].mask = 32'hF0F0;      vecs[3].rk   = 1;

        vecs[4].din  = {32'd16, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd20};
`ifdef NTT_POLY_BUFFER_REDUCE_EN
        vecs[4].exp  = {32'd16, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd3};
`else
        vecs[4].exp  = {32'd16, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd20};
`endif
        vecs[4].q    = 32'd17;        vecs[4].intt = 1'b1; vecs[4].pxor = 0;
        vecs[4].mask = 32'h0;         vecs[4].rk   = 0;

        rst = 1'b1; q_in = '0; in_intt = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; ntt_read_address = '0; ntt_write_address = '0;
        ntt_wea = 1'b0; ntt_data_out = '0; ntt_finish = 1'b0;

        // Reset values.
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ntt_start", ntt_start, 0);
        check("rst_ntt_intt", ntt_intt, 0);
        check("rst_ntt_q", ntt_q, 0);
        check("rst_ntt_data_in", ntt_data_in, 0);

        @(posedge clk); #2;
        rst = 1'b0;
        check("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("load_in_ready", in_ready, 1);
        check("load_busy", busy, 1);

        // Table-driven transactions.
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], (i == 1) ? 40 : 0);
        end

        // Reset in the middle of load beat 3.
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_data = 32'hBAD0_0000 + b; q_in = 32'hFFFF_FFF1;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 32'hBAD0_0003;
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        check("arst_rel_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("arst_reload_ready", in_ready, 1);
        r = vecs[1];
        r.din = {32'h57, 32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51, 32'h50};
        r.exp = {32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57};
        r.rk  = 0;
        run_txn("after_reset", r, 0);

        // Randomized transactions against the reference model.
        for (int it = 0; it < 8; it++) begin
            r.q    = $urandom | 32'h8000_0000;
            r.intt = 1'($urandom);
            r.pxor = $urandom_range(0, N - 1);
            r.mask = $urandom;
            r.rk   = 2;
            for (int k = 0; k < N; k++) r.din[k] = $urandom;
            for (int k = 0; k < N; k++) r.exp[k] = model_store(r.din[k ^ r.pxor], r.q) ^ r.mask;
            run_txn($sformatf("rand%0d", it), r, 30);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
